// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, error codes and header layout for the program loader
package loader_pkg;
    typedef enum logic [2:0] {IDLE, HEADER, LOAD_I, LOAD_D, CPU_RST, RUN, FIN} state_t;
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_HDR = 2'd1;
    localparam logic [1:0] ERR_LEN = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;
    localparam int N_I_LSB = 0;
    localparam int N_D_LSB = 16;
    localparam int FIELD_W = 9;
endpackage

// File: rtl/loader_counter.sv
// loader_counter: load-address counter with clear, increment and terminal-count compare
module loader_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] tc,
    output logic [W-1:0] count,
    output logic         last
);
    assign last = (count + W'(1)) == tc;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count <= '0;
        else if (clr) count <= '0;
        else if (inc) count <= count + W'(1);
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: streams a program image into instruction/data memories, then resets and runs the core
module program_loader
    import loader_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int ADDR_W = 8,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    input  logic              cpu_done,
    output logic              busy,
    output logic              done,
    output logic [1:0]        error,
    output logic [31:0]       cycles
);
    localparam logic [FIELD_W-1:0] DEPTH_F = FIELD_W'(DEPTH);
    localparam logic [FIELD_W-1:0] RST_TC = FIELD_W'(RST_CYCLES);
    localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);
    state_t state, next;
    logic [FIELD_W-1:0] n_i, n_d, cnt, tc, hdr_ni, hdr_nd;
    logic clr, inc, cnt_last, hs, bad_hdr, fin_word;
    logic [1:0] err_d;
    logic [31:0] cyc_d;
    assign in_ready = state inside {HEADER, LOAD_I, LOAD_D};
    assign busy = !(state inside {IDLE, FIN});
    assign done = state == FIN;
    assign cpu_reset = state != RUN;
    assign hs = in_valid && in_ready;
    assign hdr_ni = in_word[N_I_LSB +: FIELD_W];
    assign hdr_nd = in_word[N_D_LSB +: FIELD_W];
    assign bad_hdr = hdr_ni == '0 || hdr_ni > DEPTH_F || hdr_nd > DEPTH_F;
    // the counter also times the processor reset pulse in CPU_RST
    assign tc = state == LOAD_I ? n_i : state == LOAD_D ? n_d : RST_TC;
    assign fin_word = cnt_last && (state == LOAD_D || n_d == '0);
    loader_counter #(.W(FIELD_W)) u_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(inc), .tc(tc), .count(cnt), .last(cnt_last)
    );
    always_comb begin
        next = state;
        clr = 1'b0;
        inc = 1'b0;
        err_d = error;
        cyc_d = cycles;
        case (state)
            IDLE, FIN: if (start) begin
                next = HEADER;
                err_d = ERR_NONE;
                cyc_d = '0;
                clr = 1'b1;
            end
            HEADER: if (hs) begin
                next = (bad_hdr || in_last) ? FIN : LOAD_I;
                err_d = bad_hdr ? ERR_HDR : in_last ? ERR_LEN : ERR_NONE;
            end
            LOAD_I, LOAD_D: if (hs) begin
                inc = !cnt_last;
                clr = cnt_last;
                if (in_last != fin_word) begin
                    next = FIN;
                    err_d = ERR_LEN;
                end else if (cnt_last) next = (state == LOAD_I && n_d != '0) ? LOAD_D : CPU_RST;
            end
            CPU_RST: begin
                inc = !cnt_last;
                clr = cnt_last;
                next = cnt_last ? RUN : CPU_RST;
            end
            RUN: if (cpu_done) next = FIN;
                else if (cycles == TIMEOUT_C) begin
                    next = FIN;
                    err_d = ERR_TIMEOUT;
                end else cyc_d = cycles + 32'(cycles != '1);
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            n_i <= '0;
            n_d <= '0;
            error <= ERR_NONE;
            cycles <= '0;
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
        end else begin
            state <= next;
            error <= err_d;
            cycles <= cyc_d;
            imem_we <= hs && state == LOAD_I;
            dmem_we <= hs && state == LOAD_D;
            if (hs && state == HEADER) begin
                n_i <= hdr_ni;
                n_d <= hdr_nd;
            end
            if (hs && state != HEADER) begin
                mem_addr <= ADDR_W'(cnt);
                mem_wdata <= in_word;
            end
        end
    end
endmodule
